// File: rtl/ht16d35a_cmd_sequencer_pkg.sv
// Shared types and constants for the HT16D35A command sequencer.
// Holds the bus widths, the FSM state type, the init command entry type
// and the init table replayed after power-up when HT16D35A_INIT_TABLE_EN is set.
package ht16d35a_cmd_sequencer_pkg;

  localparam int unsigned NUM_SELECTS = 2;
  localparam int unsigned OUT_BYTES   = 8;
  localparam int unsigned COUNT_W     = $clog2(OUT_BYTES + 1);

  typedef logic [NUM_SELECTS-1:0]   cs_t;
  typedef logic [COUNT_W-1:0]       count_t;
  typedef logic [OUT_BYTES-1:0][7:0] bytes_t;   // byte [0] goes out first

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_INIT  = 3'd1,
    S_ARM   = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4,
    S_READY = 3'd5
  } seq_state_t;

  typedef struct packed {
    count_t count;
    bytes_t bytes;
  } init_cmd_t;

  localparam int unsigned INIT_LEN   = 2;
  localparam int unsigned INIT_IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  // Entry 0: software reset; entry 1: two-byte mode setup.
  localparam init_cmd_t INIT_TABLE [INIT_LEN] = '{
    '{count: count_t'(1), bytes: bytes_t'(64'h0000_0000_0000_00CC)},
    '{count: count_t'(2), bytes: bytes_t'(64'h0000_0000_0000_0F31)}
  };

  // A user command is issuable only with a non-empty chip mask and 1..OUT_BYTES bytes.
  function automatic logic cmd_legal(input cs_t cs, input count_t count);
    return (cs != '0) && (count != '0) && (count <= count_t'(OUT_BYTES));
  endfunction

endpackage

// File: rtl/ht16d35a_cmd_sequencer_if.sv
// Command/SPI bus bundle for the sequencer.
//   cmd_*  : user valid/ready command port (environment -> sequencer)
//   spi_*  : activate/busy transaction port (sequencer -> SPI controller)
// master = sequencer view, slave = environment view.
interface ht16d35a_cmd_sequencer_if
  import ht16d35a_cmd_sequencer_pkg::*;
();

  logic   cmd_valid;
  logic   cmd_ready;
  cs_t    cmd_cs;
  bytes_t cmd_data;
  count_t cmd_count;

  logic   spi_activate;
  logic   spi_busy;
  cs_t    spi_cs;
  bytes_t spi_data;
  count_t spi_count;

  modport master (
    input  cmd_valid, cmd_cs, cmd_data, cmd_count, spi_busy,
    output cmd_ready, spi_activate, spi_cs, spi_data, spi_count
  );

  modport slave (
    output cmd_valid, cmd_cs, cmd_data, cmd_count, spi_busy,
    input  cmd_ready, spi_activate, spi_cs, spi_data, spi_count
  );

endinterface

// File: rtl/ht16d35a_cmd_sequencer_init_rom.sv
// Combinational lookup of the power-up init command table.
//   idx_i   : table index
//   entry_o : {count, bytes} for that index (zero when out of range)
module ht16d35a_cmd_sequencer_init_rom
  import ht16d35a_cmd_sequencer_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx_i,
  output init_cmd_t             entry_o
);

  always_comb begin
    entry_o = '0;
    if (32'(idx_i) < INIT_LEN) entry_o = INIT_TABLE[idx_i];
  end

endmodule

// File: rtl/ht16d35a_cmd_sequencer.sv
// Upstream feeder for the HT16D35A 3-wire SPI controller: waits out the chip
// power-up time, optionally replays the init table, then turns each accepted
// user command into one activate/busy transaction.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : master modport (cmd_* in, cmd_ready out; spi_* out, spi_busy in)
//   init_done    : power-up wait and init table complete (sticky)
//   err_timeout  : busy never rose within ACK_TIMEOUT cycles of activate (sticky)
// Build option: HT16D35A_INIT_TABLE_EN enables the init table replay; without it
// the sequencer goes straight to accepting commands after power-up.
module ht16d35a_cmd_sequencer
  import ht16d35a_cmd_sequencer_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 500_000,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  ht16d35a_cmd_sequencer_if.master        bus,
  output logic                            init_done,
  output logic                            err_timeout
);

  localparam int unsigned PWRUP_W = (PWRUP_CYCLES > 0) ? $clog2(PWRUP_CYCLES + 1) : 1;
  localparam int unsigned TMO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  seq_state_t         state_q;
  logic [PWRUP_W-1:0] pwrup_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               activate_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  cs_t                cs_q;
  count_t             count_q;
  bytes_t             data_q;

  logic tmo_hit_c;
  logic advance_c;

`ifdef HT16D35A_INIT_TABLE_EN
  logic [INIT_IDX_W-1:0] idx_q;
  logic                  init_run_q;
  init_cmd_t             rom_entry;
  logic                  more_init_c;

  ht16d35a_cmd_sequencer_init_rom u_init_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  assign more_init_c = init_run_q && (idx_q != INIT_IDX_W'(INIT_LEN - 1));
`endif

  // Transaction finished: either busy came and went, or busy never came in time.
  assign tmo_hit_c = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
  assign advance_c = !bus.spi_busy &&
                     ((state_q == S_DONE) || ((state_q == S_ISSUE) && tmo_hit_c));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_PWRUP;
      pwrup_q    <= PWRUP_W'(PWRUP_CYCLES);
      tmo_q      <= '0;
      activate_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cs_q       <= '0;
      count_q    <= '0;
      data_q     <= '0;
`ifdef HT16D35A_INIT_TABLE_EN
      idx_q      <= '0;
      init_run_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_PWRUP: begin
          // Leaving on the count of 1 makes the exit land exactly PWRUP_CYCLES after reset.
          if (pwrup_q <= PWRUP_W'(1)) begin
            pwrup_q <= '0;
`ifdef HT16D35A_INIT_TABLE_EN
            state_q    <= S_INIT;
            idx_q      <= '0;
            init_run_q <= 1'b1;
`else
            state_q <= S_READY;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
`endif
          end else begin
            pwrup_q <= pwrup_q - PWRUP_W'(1);
          end
        end
`ifdef HT16D35A_INIT_TABLE_EN
        S_INIT: begin
          // Payload only moves while the controller is idle.
          if (!bus.spi_busy) begin
            cs_q    <= '1;
            count_q <= rom_entry.count;
            data_q  <= rom_entry.bytes;
            state_q <= S_ARM;
          end
        end
`endif
        S_ARM: begin
          if (!bus.spi_busy) begin
            activate_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.spi_busy) begin
            activate_q <= 1'b0;
            state_q    <= S_DONE;
          end else if (tmo_hit_c) begin
            activate_q <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_DONE: begin
          tmo_q <= '0;
        end
        S_READY: begin
          // Illegal commands are acknowledged by the handshake and then dropped.
          if (bus.cmd_valid && ready_q && cmd_legal(bus.cmd_cs, bus.cmd_count)) begin
            cs_q    <= bus.cmd_cs;
            count_q <= bus.cmd_count;
            data_q  <= bus.cmd_data;
            ready_q <= 1'b0;
            state_q <= S_ARM;
          end
        end
        default: state_q <= S_PWRUP;
      endcase

      // Move on to the next init entry or back to accepting user commands.
      if (advance_c) begin
`ifdef HT16D35A_INIT_TABLE_EN
        if (more_init_c) begin
          idx_q   <= idx_q + INIT_IDX_W'(1);
          state_q <= S_INIT;
        end else begin
          init_run_q <= 1'b0;
          state_q    <= S_READY;
          ready_q    <= 1'b1;
          done_q     <= 1'b1;
        end
`else
        state_q <= S_READY;
        ready_q <= 1'b1;
        done_q  <= 1'b1;
`endif
      end
    end
  end

  assign bus.spi_activate = activate_q;
  assign bus.spi_cs       = cs_q;
  assign bus.spi_count    = count_q;
  assign bus.spi_data     = data_q;
  assign bus.cmd_ready    = ready_q;
  assign init_done        = done_q;
  assign err_timeout      = err_q;

endmodule
